// File: rtl/ram_rw_ctrl.sv
// ram_rw_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Built-in write-then-verify engine for a simple dual-port RAM. On a start
//   pulse it writes every address with a known pattern, reads every address
//   back through a fixed-latency read path, and reports the mismatch count,
//   the first failing address and an overall pass flag.
//
//   Pattern: data(k) = (2**DATA_WIDTH - 1 - k) mod 2**DATA_WIDTH, which is
//   the bitwise inverse of k truncated/extended to DATA_WIDTH.
//
// Parameters:
//   ADDR_WIDTH  RAM address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH  RAM data width
//   RD_LATENCY  edges from ram_rd_addr launch to valid ram_rd_data (1..4)
//
// Ports:
//   sys_clk         in   sole clock, rising edge
//   rst_n           in   synchronous active-low reset
//   start           in   single-cycle request for one pass (ignored while busy)
//   busy            out  pass in progress
//   done            out  level, pass finished (cleared by next start/reset)
//   pass            out  valid while done; 1 = no mismatch
//   err_cnt         out  saturating mismatch count for the current pass
//   first_err_addr  out  address of first mismatch (0 if none)
//   ram_wr_en       out  RAM write enable
//   ram_wr_addr     out  RAM write address
//   ram_wr_data     out  RAM write data
//   ram_rd_addr     out  RAM read address
//   ram_rd_data     in   RAM read data, RD_LATENCY edges after its address
//   dbg_state       out  current FSM state encoding (IDLE=0 .. DONE=4)
//
// Handshake:
//   start is a request pulse with no ready; it is accepted only in IDLE or
//   DONE and when rst_n=1. busy=1 from the accepting edge until done rises.
// ----------------------------------------------------------------------------
module ram_rw_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                state;

  // Address currently driven on the active RAM port; wraps at all-ones.
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  addr_last;

  // High in the cycle a read address is on ram_rd_addr, i.e. the launch
  // register that feeds the delay pipeline.
  logic                  rd_launch_vld;

  // Delay pipeline: stage RD_LATENCY-1 lines up with ram_rd_data.
  logic                  pipe_vld  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];

  logic [2:0]            flush_cnt;

  logic                  cmp_fire;
  logic                  cmp_miss;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return ~DATA_WIDTH'(a);
  endfunction

  assign addr_nxt  = addr_cnt + 1'b1;
  assign addr_last = (addr_cnt == '1);
  assign dbg_state = state;

  assign cmp_fire = pipe_vld[RD_LATENCY-1];
  assign cmp_miss = cmp_fire && (ram_rd_data != pattern(pipe_addr[RD_LATENCY-1]));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_cnt       <= '0;
      rd_launch_vld  <= 1'b0;
      flush_cnt      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      ram_wr_en      <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_rd_addr    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      // Read tracking pipeline: shifts every cycle, fed by the launch register.
      pipe_vld[0]  <= rd_launch_vld;
      pipe_addr[0] <= ram_rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end

      // Compare when a tracked read leaves the pipeline. first_err_addr is
      // captured only while the count is still zero (first mismatch).
      if (cmp_miss) begin
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
        if (err_cnt == 8'd0) begin
          first_err_addr <= pipe_addr[RD_LATENCY-1];
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            // The pipeline is empty here, so clearing the result registers
            // cannot collide with a compare update.
            state          <= WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            addr_cnt       <= '0;
            ram_wr_en      <= 1'b1;
            ram_wr_addr    <= '0;
            ram_wr_data    <= pattern('0);
          end
        end

        WRITE: begin
          if (addr_last) begin
            state         <= READ;
            addr_cnt      <= '0;
            ram_wr_en     <= 1'b0;
            ram_wr_addr   <= '0;
            ram_wr_data   <= '0;
            ram_rd_addr   <= '0;
            rd_launch_vld <= 1'b1;
          end else begin
            addr_cnt    <= addr_nxt;
            ram_wr_addr <= addr_nxt;
            ram_wr_data <= pattern(addr_nxt);
          end
        end

        READ: begin
          if (addr_last) begin
            state         <= FLUSH;
            addr_cnt      <= '0;
            ram_rd_addr   <= '0;
            rd_launch_vld <= 1'b0;
            flush_cnt     <= '0;
          end else begin
            addr_cnt    <= addr_nxt;
            ram_rd_addr <= addr_nxt;
          end
        end

        FLUSH: begin
          // The last read is compared on the edge where flush_cnt becomes
          // RD_LATENCY; DONE follows one edge later so pass sees the final
          // err_cnt value.
          if (flush_cnt == 3'(RD_LATENCY)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 8'd0);
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// tb_ram_rw_ctrl
// Three DUT instances share clock and reset:
//   u0: defaults (6/8/2) with a RAM model that can corrupt address 5
//   u1: ADDR_WIDTH=9 with a read port that always returns 0
//   u2: RD_LATENCY=1 with an ideal RAM model
// Drivers push expected write beats and pass results into queues; a monitor
// on the falling edge pops and compares whenever the DUT writes or raises done.
module tb_ram_rw_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // u0 signals
  logic       busy0, done0, pass0, wr_en0;
  logic [7:0] err0, wr_data0, rd_data0;
  logic [5:0] first0, wr_addr0, rd_addr0;
  logic [2:0] dbg0;
  // u1 signals
  logic       busy1, done1, pass1, wr_en1;
  logic [7:0] err1, wr_data1;
  logic [8:0] first1, wr_addr1, rd_addr1;
  logic [2:0] dbg1;
  // u2 signals
  logic       busy2, done2, pass2, wr_en2;
  logic [7:0] err2, wr_data2, rd_data2;
  logic [5:0] first2, wr_addr2, rd_addr2;
  logic [2:0] dbg2;

  ram_rw_ctrl u0 (
    .sys_clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .first_err_addr(first0), .ram_wr_en(wr_en0),
    .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0), .ram_rd_addr(rd_addr0),
    .ram_rd_data(rd_data0), .dbg_state(dbg0)
  );

  ram_rw_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .RD_LATENCY(2)) u1 (
    .sys_clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .first_err_addr(first1), .ram_wr_en(wr_en1),
    .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1), .ram_rd_addr(rd_addr1),
    .ram_rd_data(8'h00), .dbg_state(dbg1)
  );

  ram_rw_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .RD_LATENCY(1)) u2 (
    .sys_clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2), .first_err_addr(first2), .ram_wr_en(wr_en2),
    .ram_wr_addr(wr_addr2), .ram_wr_data(wr_data2), .ram_rd_addr(rd_addr2),
    .ram_rd_data(rd_data2), .dbg_state(dbg2)
  );

  // RAM models
  logic [7:0] mem0 [64];
  logic [7:0] mem2 [64];
  logic [7:0] p0a = 8'h00, p0b = 8'h00, p2a = 8'h00;
  bit         corrupt5 = 1'b0;

  always @(posedge clk) begin
    if (wr_en0) mem0[wr_addr0] <= wr_data0;
    if (wr_en2) mem2[wr_addr2] <= wr_data2;
    p0a <= mem0[rd_addr0] ^ ((corrupt5 && rd_addr0 == 6'd5) ? 8'h01 : 8'h00);
    p0b <= p0a;
    p2a <= mem2[rd_addr2];
  end
  assign rd_data0 = p0b;
  assign rd_data2 = p2a;

  // Scoreboard queues
  logic [13:0] wr_q0 [$];   // {addr, data}
  logic [49:0] res_q0 [$];  // {edge, pass, err_cnt, first_err_addr}
  logic [49:0] res_q1 [$];
  logic [49:0] res_q2 [$];

  function automatic logic [49:0] pk(input int e, input logic p,
                                     input logic [7:0] er, input logic [8:0] f);
    return {e, p, er, f};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor
  logic d0q = 1'b0, d1q = 1'b0, d2q = 1'b0;
  always @(negedge clk) begin
    if (wr_en0) begin
      if (wr_q0.size() == 0) chk("wr0_unexpected", {wr_addr0, wr_data0}, 64'h0);
      else chk("wr0_beat", {wr_addr0, wr_data0}, wr_q0.pop_front());
    end
    if (done0 && !d0q) begin
      if (res_q0.size() == 0) chk("res0_unexpected", 64'd1, 64'd0);
      else chk("res0", pk(cyc, pass0, err0, {3'b0, first0}), res_q0.pop_front());
    end
    if (done1 && !d1q) begin
      if (res_q1.size() == 0) chk("res1_unexpected", 64'd1, 64'd0);
      else chk("res1", pk(cyc, pass1, err1, first1), res_q1.pop_front());
    end
    if (done2 && !d2q) begin
      if (res_q2.size() == 0) chk("res2_unexpected", 64'd1, 64'd0);
      else chk("res2", pk(cyc, pass2, err2, {3'b0, first2}), res_q2.pop_front());
    end
    d0q <= done0;
    d1q <= done1;
    d2q <= done2;
  end

  // Driver tasks
  task automatic push_writes0();
    for (int k = 0; k < 64; k++) wr_q0.push_back({6'(k), 8'(8'hFF - k)});
  endtask

  // Returns the index of the edge that samples start.
  task automatic pulse_start(input int which, output int s);
    @(negedge clk);
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    s = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = done0;
        1: seen = done1;
        default: seen = done2;
      endcase
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_done%0d timeout after %0d cycles", which, bound);
    end
  endtask

  initial begin
    int s;
    bit hit;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_status", {busy0, done0, pass0, err0, first0}, 0);
    chk("rst_ram", {wr_en0, wr_addr0, wr_data0, rd_addr0}, 0);
    chk("rst_state", dbg0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pass 1: ideal RAM, done at start edge + 131
    push_writes0();
    pulse_start(0, s);
    res_q0.push_back(pk(s + 131, 1'b1, 8'd0, 9'd0));
    chk("busy_after_start", {busy0, done0}, 2'b10);
    wait_done(0, 300);

    // Pass 2 started from DONE: corrupted read at address 5
    corrupt5 = 1'b1;
    push_writes0();
    pulse_start(0, s);
    res_q0.push_back(pk(s + 131, 1'b0, 8'd1, 9'd5));
    chk("done_drop_on_restart", {busy0, done0}, 2'b10);
    wait_done(0, 300);
    corrupt5 = 1'b0;

    // Pass 3: start re-pulsed mid-READ must be ignored
    push_writes0();
    pulse_start(0, s);
    res_q0.push_back(pk(s + 131, 1'b1, 8'd0, 9'd0));
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (rd_addr0 == 6'd10);
    end
    chk("reach_read10", hit, 1'b1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("start_ignored_state", dbg0, 3'd2);
    wait_done(0, 300);

    // Pass 4: reset during WRITE at address 20, start held during reset
    push_writes0();
    pulse_start(0, s);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (wr_en0 && wr_addr0 == 6'd20) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_write20", hit, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_status", {busy0, done0, pass0, err0, first0}, 0);
    chk("midrst_ram", {wr_en0, wr_addr0, wr_data0, rd_addr0}, 0);
    chk("midrst_state", dbg0, 0);
    wr_q0.delete();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    rst_n = 1'b1;
    chk("start_in_reset_ignored", {busy0, dbg0}, 0);
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy0, dbg0, wr_en0}, 0);

    // Pass 5: fresh pass after reset begins at address 0 and passes
    push_writes0();
    pulse_start(0, s);
    res_q0.push_back(pk(s + 131, 1'b1, 8'd0, 9'd0));
    wait_done(0, 300);

    // u1: all-zero reads over 512 addresses saturate err_cnt
    pulse_start(1, s);
    res_q1.push_back(pk(s + 2 * 512 + 2 + 1, 1'b0, 8'd255, 9'd0));
    wait_done(1, 1500);

    // u2: RD_LATENCY=1, done at start edge + 130
    pulse_start(2, s);
    res_q2.push_back(pk(s + 130, 1'b1, 8'd0, 9'd0));
    wait_done(2, 300);

    repeat (3) @(negedge clk);
    chk("wr_q0_drained", wr_q0.size(), 0);
    chk("res_q0_drained", res_q0.size(), 0);
    chk("res_q1_drained", res_q1.size(), 0);
    chk("res_q2_drained", res_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rw_ctrl.md
RAM_RW_CTRL -- requirements
Module: ram_rw_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 6, RAM address width; depth is 2**ADDR_WIDTH.
REQ-002 Parameter: DATA_WIDTH, 8, RAM data width.
REQ-003 Parameter: RD_LATENCY, 2, cycles from ram_rd_addr launch to valid ram_rd_data (output register enabled), range 1..4.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  single-cycle request to run one write-then-verify pass.
REQ-008 busy  out  1  high while a pass is in progress.
REQ-009 done  out  1  level, high after a pass completes until the next start or reset.
REQ-010 pass  out  1  valid while done=1; 1 when no mismatch was found.
REQ-011 err_cnt  out  8  mismatch count for the current pass, saturating.
REQ-012 first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the current pass.
REQ-013 ram_wr_en  out  1  RAM write enable.
REQ-014 ram_wr_addr  out  ADDR_WIDTH  RAM write address.
REQ-015 ram_wr_data  out  DATA_WIDTH  RAM write data.
REQ-016 ram_rd_addr  out  ADDR_WIDTH  RAM read address.
REQ-017 ram_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after its address.

Function
REQ-018 States: IDLE, WRITE, READ, FLUSH, DONE; all ram_* outputs and status outputs are registered.
REQ-019 IDLE or DONE, start=1 -> WRITE; clear done, pass, err_cnt, first_err_addr; set busy.
REQ-020 start while busy=1 is ignored, with no effect on state, counters or outputs.
REQ-021 WRITE: one word per cycle, ram_wr_en=1, address k = 0..2**ADDR_WIDTH-1 ascending, ram_wr_data = (2**DATA_WIDTH-1-k) mod 2**DATA_WIDTH.
REQ-022 WRITE -> READ after address all-ones is written; ram_wr_en=0 in the next cycle.
REQ-023 READ: ram_rd_addr k = 0..2**ADDR_WIDTH-1 ascending, one per cycle; READ -> FLUSH after address all-ones is launched.
REQ-024 A RD_LATENCY-deep pipeline carries a valid flag and the address of each launched read; the compare fires when the flag exits the pipeline.
REQ-025 Compare: expected = (2**DATA_WIDTH-1-addr) mod 2**DATA_WIDTH; a mismatch increments err_cnt and holds it at 255 once reached.
REQ-026 first_err_addr loads only on the first mismatch of a pass; it stays 0 when no mismatch occurs.
REQ-027 FLUSH lasts RD_LATENCY cycles so the last read is compared, then -> DONE.
REQ-028 DONE: busy=0, done=1, pass=(err_cnt==0).
REQ-029 Latency: done rises 2*2**ADDR_WIDTH+RD_LATENCY+1 edges after the edge sampling start (131 at defaults).
REQ-030 Outside WRITE: ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0. Outside READ: ram_rd_addr=0.
REQ-031 The address counter wraps internally at all-ones; it never drives an address beyond depth-1.

Reset
REQ-032 rst_n=0 at a rising edge -> IDLE; busy, done, pass, err_cnt, first_err_addr, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr all 0; read pipeline valid flags cleared.
REQ-033 Reset in any state aborts the pass; no compare from pre-reset reads fires after reset; the next start restarts at address 0.
REQ-034 start sampled together with rst_n=0 is ignored.

Verification
REQ-035 Ideal RAM model (latency 2), defaults, start pulse -> 64 writes with data FF..C0, done=1 at edge 131, pass=1, err_cnt=0, first_err_addr=0.
REQ-036 Model corrupts read of address 5 (XOR 0x01) -> err_cnt=1, first_err_addr=5, pass=0.
REQ-037 Model returns 0x00 for all reads, ADDR_WIDTH=9 -> err_cnt saturates at 255, first_err_addr=0, pass=0.
REQ-038 rst_n=0 for 1 cycle during WRITE at address 20 -> all outputs 0 next cycle; a new start writes from address 0 and passes.
REQ-039 start re-pulsed mid-READ -> ignored, done still at edge 131; start in DONE -> done drops next cycle and a fresh pass runs.
REQ-040 RD_LATENCY=1 with a matching model -> pass=1, done at edge 130.
